// File: rtl/alu_op_driver.sv
// Sequential initiator for the lab's combinational ALU: collects opcode/A/B words,
// pulses the one-hot function select for one cycle, returns y. Optional: ALU_OP_DRIVER_ZERO_FLAG_EN.
module alu_op_driver #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [NUM_OPS-1:0] alu_f,
    input  logic [WIDTH-1:0]   alu_y,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
`ifdef ALU_OP_DRIVER_ZERO_FLAG_EN
    ,
    output logic               out_zero
`endif
);

    // state  | meaning
    // GET_OP | waiting for opcode word
    // GET_A  | waiting for operand A
    // GET_B  | waiting for operand B
    // EXEC   | ALU driven with decoded select, result captured at the edge
    // DONE   | result presented until the consumer takes it
    typedef enum logic [2:0] {
        GET_OP,
        GET_A,
        GET_B,
        EXEC,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] opcode;
    logic       in_xfer;
    logic       out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Outputs are decoded from the registered state only; rst gating keeps them
    // quiet during the reset cycle regardless of where the FSM was.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        alu_f     = '0;
        case (state)
            GET_OP: begin
                in_ready = !rst;
                if (in_xfer) state_nxt = GET_A;
            end
            GET_A: begin
                in_ready = !rst;
                if (in_xfer) state_nxt = GET_B;
            end
            GET_B: begin
                in_ready = !rst;
                if (in_xfer) state_nxt = EXEC;
            end
            EXEC: begin
                if (!rst && (opcode < 4'(NUM_OPS)))
                    alu_f = NUM_OPS'(1) << opcode;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_xfer) state_nxt = GET_OP;
            end
            default: state_nxt = GET_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GET_OP;
            opcode    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_OP_DRIVER_ZERO_FLAG_EN
            out_zero  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                GET_OP: if (in_xfer) opcode <= in_data[3:0];
                GET_A:  if (in_xfer) alu_a <= in_data;
                GET_B:  if (in_xfer) alu_b <= in_data;
                EXEC: begin
                    out_data  <= alu_y;
                    out_err   <= (opcode > 4'(NUM_OPS - 1));
                    out_valid <= 1'b1;
`ifdef ALU_OP_DRIVER_ZERO_FLAG_EN
                    out_zero  <= (alu_y == '0);
`endif
                end
                DONE: if (out_xfer) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: directed cases plus randomized commands with
// stall gaps and backpressure, checked against a behavioural opcode-level model.
module tb_alu_op_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [11:0] alu_f;
    logic [31:0] alu_y;
    logic [31:0] out_data;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
`ifdef ALU_OP_DRIVER_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_driver dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ALU_OP_DRIVER_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    // Lab ALU: combinational, keyed on the one-hot select; unknown selects give 0.
    always_comb begin
        alu_y = 32'h0;
        case (alu_f)
            12'h001: alu_y = alu_a + alu_b;
            12'h002: alu_y = alu_a - alu_b;
            12'h004: alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
            12'h008: alu_y = {31'h0, alu_a < alu_b};
            12'h010: alu_y = alu_a & alu_b;
            12'h020: alu_y = alu_a | alu_b;
            12'h040: alu_y = ~(alu_a | alu_b);
            12'h080: alu_y = alu_a ^ alu_b;
            12'h100: alu_y = alu_a << alu_b[4:0];
            12'h200: alu_y = alu_a >> alu_b[4:0];
            12'h400: alu_y = $signed(alu_a) >>> alu_b[4:0];
            12'h800: alu_y = alu_b;
            default: alu_y = 32'h0;
        endcase
    end

    // Reference: what a command should return, straight from opcode number and operands.
    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0:  return 32'(a + b);
            1:  return 32'(a - b);
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return a | b;
            6:  return ~(a | b);
            7:  return a ^ b;
            8:  return 32'(longint'(a) * (longint'(1) << b[4:0]));
            9:  return 32'(longint'(a) / (longint'(1) << b[4:0]));
            10: return 32'(sa >>> b[4:0]);
            11: return b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("in_ready_wait", {31'h0, in_ready}, 32'h1);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called one cycle after the B transfer edge, i.e. in EXEC.
    task automatic finish_cmd(input int op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        logic [11:0] exp_f;
        exp   = ref_result(op, a, b);
        exp_f = (op < 12) ? 12'(1 << op) : 12'h0;
        check_eq("exec_alu_f", {20'h0, alu_f}, {20'h0, exp_f});
        check_eq("exec_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("exec_in_ready", {31'h0, in_ready}, 32'h0);
        check_eq("alu_a", alu_a, a);
        check_eq("alu_b", alu_b, b);
        tick();
        check_eq("done_out_valid", {31'h0, out_valid}, 32'h1);
        check_eq("done_out_data", out_data, exp);
        check_eq("done_out_err", {31'h0, out_err}, {31'h0, (op > 11)});
        check_eq("done_alu_f", {20'h0, alu_f}, 32'h0);
`ifdef ALU_OP_DRIVER_ZERO_FLAG_EN
        check_eq("done_out_zero", {31'h0, out_zero}, {31'h0, (exp == 32'h0)});
`endif
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("hold_out_valid", {31'h0, out_valid}, 32'h1);
            check_eq("hold_out_data", out_data, exp);
            check_eq("hold_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("xfer_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("xfer_in_ready", {31'h0, in_ready}, 32'h1);
        check_eq("retain_alu_a", alu_a, a);
    endtask

    task automatic run_cmd(input logic [31:0] opw, input logic [31:0] a, input logic [31:0] b,
                           input int gap, input int hold);
        send_word(opw, gap);
        send_word(a, gap);
        send_word(b, gap);
        finish_cmd(int'(opw[3:0]), a, b, hold);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
        check_eq({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check_eq({tag, "_out_data"}, out_data, 32'h0);
        check_eq({tag, "_out_err"}, {31'h0, out_err}, 32'h0);
        check_eq({tag, "_alu_a"}, alu_a, 32'h0);
        check_eq({tag, "_alu_b"}, alu_b, 32'h0);
        check_eq({tag, "_alu_f"}, {20'h0, alu_f}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rop;
        rst       = 1'b1;
        in_data   = 32'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_eq("idle_in_ready", {31'h0, in_ready}, 32'h1);

        run_cmd(32'h0, 32'd5, 32'd3, 0, 0);
        run_cmd(32'h1, 32'd3, 32'd5, 0, 0);
        run_cmd(32'h2, 32'hFFFFFFFF, 32'd1, 0, 0);
        run_cmd(32'h3, 32'hFFFFFFFF, 32'd1, 0, 0);
        run_cmd(32'hD, 32'd7, 32'd9, 0, 0);
        run_cmd(32'hFFFFFFF0, 32'd2, 32'd3, 0, 0);
        run_cmd(32'h8, 32'h1, 32'd4, 0, 4);

        // Opcode offered during DONE must wait until after the result transfer.
        send_word(32'h0, 0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        tick();
        check_eq("bp_out_data", out_data, 32'd3);
        in_data  = 32'h7;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_xfer_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("bp_getop_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        send_word(32'd6, 0);
        send_word(32'd3, 0);
        finish_cmd(7, 32'd6, 32'd3, 0);

        // Reset mid-command discards the partial add.
        send_word(32'h0, 0);
        send_word(32'd10, 0);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        run_cmd(32'd11, 32'h0, 32'h1234, 0, 0);

        for (int k = 0; k < 20; k++) begin
            rop = 32'($urandom_range(0, 15)) | ($urandom() & 32'hFFFFFFF0);
            ra  = $urandom();
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = $urandom_range(0, 40);
                default: rb = $urandom();
            endcase
            run_cmd(rop, ra, rb, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
